// File: rtl/packing_fifo_if.sv
// packing_fifo_if
//   Bundles the CPU-side write port, the pop request and the read/status
//   outputs of packing_fifo.
//   master : the producer/consumer side (drives we, wr_data, wr_last, re)
//   slave  : the FIFO itself (drives rd_data, rd_valid, status and error flags)
//   Parameters IN_W, RATIO and ADDR must match the packing_fifo instance.
interface packing_fifo_if #(
  parameter int IN_W  = 16,
  parameter int RATIO = 2,
  parameter int ADDR  = 9
);
  logic                  we;
  logic [IN_W-1:0]       wr_data;
  logic                  wr_last;
  logic                  re;
  logic [IN_W*RATIO-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output we, wr_data, wr_last, re,
    input  rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  we, wr_data, wr_last, re,
    output rd_data, rd_valid, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/packing_fifo.sv
// packing_fifo
//   Packs RATIO sub-words of IN_W bits (MSB-first) into one OUT_W-bit entry
//   and queues the entries in a 2^ADDR deep FIFO with a synchronous read port.
//   clk     : clock, all state changes on the rising edge
//   reset   : synchronous active-high reset
//   flush_i : synchronous clear of the queue, same effect as reset
//   bus     : packing_fifo_if.slave
//             we/wr_data/wr_last  write one sub-word, wr_last commits early
//             re                  pop one entry
//             rd_data/rd_valid    registered read data, one-cycle valid pulse
//             full/empty/almost_full/count  status from the registered count
//             overflow/underflow  sticky error flags
module packing_fifo #(
  parameter int IN_W     = 16,
  parameter int RATIO    = 2,
  parameter int ADDR     = 9,
  parameter int AF_LEVEL = (1 << ADDR) - 8
) (
  input logic           clk,
  input logic           reset,
  input logic           flush_i,
  packing_fifo_if.slave bus
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int DEPTH = 1 << ADDR;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATIO - 1);
  localparam logic [ADDR:0]    DEPTH_CNT = (ADDR + 1)'(DEPTH);

  logic [OUT_W-1:0] mem [DEPTH];

  logic [ADDR-1:0]  wrPtr_q, wrPtr_d;
  logic [ADDR-1:0]  rdPtr_q, rdPtr_d;
  logic [ADDR:0]    count_q, count_d;
  logic [IDX_W-1:0] packIdx_q, packIdx_d;
  logic [OUT_W-1:0] partial_q, partial_d;
  logic [OUT_W-1:0] rdData_q;
  logic             rdValid_q, rdValid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             clear;
  logic             full;
  logic             empty;
  logic             wrAccept;
  logic             rdAccept;
  logic             commit;
  logic [OUT_W-1:0] packedWord;

  assign clear    = reset | flush_i;
  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign wrAccept = bus.we & ~full;
  assign rdAccept = bus.re & ~empty;
  assign commit   = wrAccept & (bus.wr_last | (packIdx_q == LAST_IDX));

  // Partial entry with the incoming sub-word dropped into its slot; slots not
  // yet written are still zero because partial_q is cleared on every commit.
  always_comb begin
    packedWord = partial_q;
    for (int k = 0; k < RATIO; k++) begin
      if (packIdx_q == IDX_W'(k)) begin
        packedWord[OUT_W-1-k*IN_W -: IN_W] = bus.wr_data;
      end
    end
  end

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    packIdx_d   = packIdx_q;
    partial_d   = partial_q;
    rdValid_d   = rdAccept;
    overflow_d  = overflow_q  | (bus.we & full);
    underflow_d = underflow_q | (bus.re & empty);

    if (wrAccept) begin
      if (commit) begin
        packIdx_d = '0;
        partial_d = '0;
        wrPtr_d   = wrPtr_q + 1'b1;
      end else begin
        packIdx_d = packIdx_q + 1'b1;
        partial_d = packedWord;
      end
    end

    if (rdAccept) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end

    case ({commit, rdAccept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      packIdx_q   <= '0;
      partial_q   <= '0;
      rdValid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      packIdx_q   <= packIdx_d;
      partial_q   <= partial_d;
      rdValid_q   <= rdValid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Write and read never target the same slot in one cycle: a pop needs
  // count>0 and a commit needs count<DEPTH, so equal pointers imply one of
  // them is blocked.
  always_ff @(posedge clk) begin
    if (commit && !clear) begin
      mem[wrPtr_q] <= packedWord;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rdData_q <= '0;
    end else if (rdAccept) begin
      rdData_q <= mem[rdPtr_q];
    end
  end

  assign bus.rd_data     = rdData_q;
  assign bus.rd_valid    = rdValid_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (int'(count_q) >= AF_LEVEL);
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_packing_fifo.sv
// tb_packing_fifo
//   Directed bench for packing_fifo (IN_W=16, RATIO=2, ADDR=2, AF_LEVEL=3).
//   Expected pop data is queued when a pop is issued; a monitor compares it
//   whenever rd_valid is seen. Status flags are checked inline.
module tb_packing_fifo;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  packing_fifo_if #(.IN_W(16), .RATIO(2), .ADDR(2)) bus ();

  packing_fifo #(
    .IN_W(16), .RATIO(2), .ADDR(2), .AF_LEVEL(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .bus     (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] expQ [$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, then returns 1ns after the rising edge.
  task automatic applyStimulus(input logic we, input logic [15:0] data,
                               input logic last, input logic re);
    bus.we      = we;
    bus.wr_data = data;
    bus.wr_last = last;
    bus.re      = re;
    @(posedge clk);
    #1;
    bus.we      = 1'b0;
    bus.wr_last = 1'b0;
    bus.re      = 1'b0;
  endtask

  task automatic writeWord(input logic [15:0] data, input logic last);
    applyStimulus(1'b1, data, last, 1'b0);
  endtask

  task automatic popExpect(input logic [31:0] value);
    expQ.push_back(value);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpectedPop: got rd_valid with %0h, expected no pop", bus.rd_data);
      end else begin
        checkOutput("popData", {32'h0, bus.rd_data}, {32'h0, expQ.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] hi;
    logic [15:0] lo;
    logic [31:0] entries [10];

    reset       = 1'b1;
    flush       = 1'b0;
    bus.we      = 1'b0;
    bus.wr_data = 16'h0;
    bus.wr_last = 1'b0;
    bus.re      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("resetCount",     bus.count,       0);
    checkOutput("resetEmpty",     bus.empty,       1);
    checkOutput("resetFull",      bus.full,        0);
    checkOutput("resetAlmostFull",bus.almost_full, 0);
    checkOutput("resetOverflow",  bus.overflow,    0);
    checkOutput("resetUnderflow", bus.underflow,   0);
    checkOutput("resetRdValid",   bus.rd_valid,    0);
    checkOutput("resetRdData",    bus.rd_data,     0);

    $display("[TB] basic pack and pop");
    writeWord(16'hAAAA, 1'b0);
    checkOutput("partialNotCounted", bus.count, 0);
    checkOutput("partialEmpty",      bus.empty, 1);
    writeWord(16'h5555, 1'b0);
    checkOutput("countAfterCommit", bus.count, 1);
    popExpect(32'hAAAA5555);
    checkOutput("countAfterPop", bus.count,    0);
    checkOutput("emptyAfterPop", bus.empty,    1);
    checkOutput("rdValidPulse",  bus.rd_valid, 1);
    idle();
    checkOutput("rdValidOneCycle", bus.rd_valid, 0);

    $display("[TB] early commit with zero padding");
    writeWord(16'h1234, 1'b1);
    checkOutput("countAfterLast", bus.count, 1);
    popExpect(32'h12340000);
    idle();

    $display("[TB] fill, almost_full, full, overflow");
    writeWord(16'h1111, 1'b0); writeWord(16'h2222, 1'b0);
    writeWord(16'h3333, 1'b0); writeWord(16'h4444, 1'b0);
    writeWord(16'h5555, 1'b0); writeWord(16'h6666, 1'b0);
    checkOutput("afAtThree",   bus.almost_full, 1);
    checkOutput("notFullThree",bus.full,        0);
    writeWord(16'h7777, 1'b0); writeWord(16'h8888, 1'b0);
    checkOutput("fullAtFour",  bus.full,  1);
    checkOutput("countFour",   bus.count, 4);
    checkOutput("noOverflowYet", bus.overflow, 0);
    writeWord(16'h9999, 1'b0);
    checkOutput("overflowSet",      bus.overflow, 1);
    checkOutput("countAfterDrop",   bus.count,    4);
    popExpect(32'h11112222);
    checkOutput("countAfterFullPop", bus.count, 3);
    writeWord(16'hBBBB, 1'b0); writeWord(16'hCCCC, 1'b0);
    checkOutput("refill", bus.count, 4);
    popExpect(32'h33334444);
    popExpect(32'h55556666);
    popExpect(32'h77778888);
    popExpect(32'hBBBBCCCC);
    idle();
    checkOutput("overflowSticky", bus.overflow, 1);
    checkOutput("drainedEmpty",   bus.empty,    1);

    $display("[TB] underflow");
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("underflowNoValid", bus.rd_valid,  0);
    checkOutput("underflowHold",    bus.rd_data,   32'hBBBBCCCC);
    checkOutput("underflowSet",     bus.underflow, 1);
    idle();
    checkOutput("underflowSticky",  bus.underflow, 1);
    flush = 1'b1;
    idle();
    flush = 1'b0;
    checkOutput("flushUnderflow", bus.underflow, 0);
    checkOutput("flushOverflow",  bus.overflow,  0);
    checkOutput("flushRdData",    bus.rd_data,   0);

    $display("[TB] steady state and pointer wrap");
    for (int i = 0; i < 10; i++) begin
      hi = 16'h1000 + 16'(i);
      lo = 16'h2000 + 16'(i);
      entries[i] = {hi, lo};
    end
    for (int i = 0; i < 2; i++) begin
      writeWord(entries[i][31:16], 1'b0);
      writeWord(entries[i][15:0],  1'b0);
    end
    checkOutput("steadyStart", bus.count, 2);
    for (int i = 2; i < 10; i++) begin
      writeWord(entries[i][31:16], 1'b0);
      expQ.push_back(entries[i-2]);
      applyStimulus(1'b1, entries[i][15:0], 1'b0, 1'b1);
      checkOutput("steadyCount", bus.count, 2);
    end
    popExpect(entries[8]);
    popExpect(entries[9]);
    checkOutput("wrapEmpty", bus.empty, 1);
    idle();

    $display("[TB] reset mid-pack");
    writeWord(16'hFFFF, 1'b0);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checkOutput("midPackResetCount", bus.count, 0);
    writeWord(16'h0001, 1'b0);
    writeWord(16'h0002, 1'b0);
    checkOutput("afterResetCount", bus.count, 1);
    popExpect(32'h00010002);

    repeat (3) idle();
    checkOutput("scoreboardDrained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/packing_fifo.md
PACKING_FIFO -- requirements
Module: packing_fifo

Interface
REQ-001 SHALL have parameter IN_W, default 16, width of one CPU write word.
REQ-002 SHALL have parameter RATIO, default 2, number of IN_W words packed per FIFO entry (legal >= 1).
REQ-003 SHALL have parameter ADDR, default 9, FIFO depth DEPTH = 2^ADDR entries.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-8, almost-full threshold in entries.
REQ-005 SHALL derive OUT_W = IN_W*RATIO.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  synchronous clear of queue contents, same effect as reset.
REQ-009 we  input  1  write one IN_W sub-word.
REQ-010 wr_data  input  IN_W  sub-word to pack.
REQ-011 wr_last  input  1  with we: commit the current entry after this sub-word, zero-padding the unwritten sub-words.
REQ-012 re  input  1  pop one entry.
REQ-013 rd_data  output  OUT_W  registered read data.
REQ-014 rd_valid  output  1  one-cycle pulse: rd_data updated by an accepted pop.
REQ-015 full, empty, almost_full  output  1 each  status flags.
REQ-016 count  output  ADDR+1  committed entries held (0..DEPTH).
REQ-017 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-018 Packing order SHALL be MSB-first: the first sub-word of an entry lands in bits [OUT_W-1:OUT_W-IN_W], each following sub-word IN_W bits lower.
REQ-019 A pack index (0..RATIO-1) SHALL advance on each accepted write; an accepted write at index RATIO-1, or with wr_last=1, SHALL commit the entry to memory at wr_ptr in that same clock edge and reset the index to 0.
REQ-020 With RATIO=1, every accepted write SHALL commit.
REQ-021 A write SHALL be accepted only when full=0; a write with full=1 SHALL be dropped, leaving pack index, partial data and pointers unchanged, and SHALL set overflow.
REQ-022 A pop SHALL be accepted only when empty=0; rd_data <= mem[rd_ptr] and rd_ptr advances at that edge, rd_valid=1 in the following cycle; latency re -> rd_data = 1 clock.
REQ-023 A pop with empty=1 SHALL be ignored, leave rd_data unchanged, keep rd_valid=0, and set underflow.
REQ-024 rd_ptr and wr_ptr SHALL be ADDR bits wide and wrap from DEPTH-1 to 0.
REQ-025 count SHALL: +1 on commit only, -1 on accepted pop only, unchanged on simultaneous commit and accepted pop.
REQ-026 full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), all derived from registered count; an entry committed at edge N SHALL be poppable from edge N+1.
REQ-027 Partially packed sub-words SHALL NOT be counted or readable until committed.
REQ-028 overflow and underflow SHALL remain set until reset or flush.
REQ-029 Storage SHALL be an internal inferred dual-port array: one write port, one synchronous read port.

Reset
REQ-030 On reset or flush: rd_ptr=0, wr_ptr=0, count=0, pack index=0, partial data=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_full=0.
REQ-031 Reset/flush SHALL take priority over simultaneous we/re; memory contents need not be cleared.
REQ-032 Reset mid-pack SHALL discard the partial entry.

Verification (IN_W=16, RATIO=2, ADDR=2, AF_LEVEL=3)
REQ-033 Writes 0xAAAA, 0x5555, then re -> count 1 after 2nd write; rd_data=0xAAAA5555, rd_valid pulse one cycle after re; count 0, empty=1.
REQ-034 Write 0x1234 with wr_last=1, pop -> rd_data=0x12340000.
REQ-035 Commit 4 entries -> almost_full=1 at count 3, full=1 at count 4; 9th write dropped, overflow=1, next pop returns 1st entry intact.
REQ-036 re with empty=1 -> rd_valid stays 0, rd_data unchanged, underflow=1; cleared only by flush.
REQ-037 Steady state with count=2: commit and pop on the same edge -> count stays 2; run 10 entries through to exercise pointer wrap, data order preserved.
REQ-038 Write one sub-word, assert reset, then write 0x0001, 0x0002 -> popped entry = 0x00010002 (partial discarded).
